// File: rtl/if_pc_unit_pkg.sv
// Shared types and constants for the fetch-stage PC unit.
// FSM states, redirect sources and PC alignment helper.
package if_pc_unit_pkg;

  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] RESET_VECTOR_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HALT
  } fsm_e;

  typedef enum logic [1:0] {
    RD_NONE,
    RD_JAL,
    RD_BR,
    RD_JALR
  } redir_e;

  function automatic logic [PC_W-1:0] align_pc(
    input logic [PC_W-1:0] t
  );
    return {t[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_perf_counters.sv
// Saturating fetch-stage performance counters.
// Built only when IF_PERF_EN is defined.
module if_perf_counters #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         inc_fetch,
  input  logic         inc_stall,
  input  logic         inc_redir,
  output logic [W-1:0] fetch_cnt,
  output logic [W-1:0] stall_cnt,
  output logic [W-1:0] redir_cnt
);

  logic [W-1:0] fetch_q, fetch_d;
  logic [W-1:0] stall_q, stall_d;
  logic [W-1:0] redir_q, redir_d;

  function automatic logic [W-1:0] sat_inc(
    input logic [W-1:0] c,
    input logic         inc
  );
    return (inc && !(&c)) ? c + 1'b1 : c;
  endfunction

  always_comb begin
    fetch_d = fetch_q;
    stall_d = stall_q;
    redir_d = redir_q;
    if (en) begin
      fetch_d = sat_inc(fetch_q, inc_fetch);
      stall_d = sat_inc(stall_q, inc_stall);
      redir_d = sat_inc(redir_q, inc_redir);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_q <= '0;
      stall_q <= '0;
      redir_q <= '0;
    end else begin
      fetch_q <= fetch_d;
      stall_q <= stall_d;
      redir_q <= redir_d;
    end
  end

  assign fetch_cnt = fetch_q;
  assign stall_cnt = stall_q;
  assign redir_cnt = redir_q;

endmodule

// File: rtl/if_pc_unit.sv
// Fetch PC register, next-PC select, flush strobes and BOOT/RUN/HALT FSM.
// Define IF_PERF_EN to add the saturating performance counters.
module if_pc_unit
  import if_pc_unit_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_VECTOR = RESET_VECTOR_DEF
`ifdef IF_PERF_EN
  ,
  parameter int PERF_W = 32
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_f,
  input  logic              jal_d,
  input  logic [PC_W-1:0]   jal_target_d,
  input  logic              br_e,
  input  logic [PC_W-1:0]   br_target_e,
  input  logic              jalr_e,
  input  logic [PC_W-1:0]   jalr_target_e,
  input  logic              halt_req,
  input  logic              resume,
  output logic [PC_W-1:0]   pc_f,
  output logic              fetch_valid_f,
  output logic              flush_d,
  output logic              flush_e,
  output logic              halted
`ifdef IF_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_fetch,
  output logic [PERF_W-1:0] perf_stall,
  output logic [PERF_W-1:0] perf_redirect
`endif
);

  fsm_e            state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            fv_q, fv_d;
  logic            hp_q, hp_d;
  redir_e          src;
  logic            ex_redir;
  logic            taken;

  assign ex_redir = jalr_e | br_e;

  always_comb begin
    src = RD_NONE;
    if (jalr_e)               src = RD_JALR;
    else if (br_e)            src = RD_BR;
    else if (!stall_f && jal_d) src = RD_JAL;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hp_d    = hp_q;
    flush_d = 1'b0;
    flush_e = 1'b0;
    taken   = 1'b0;
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        unique case (src)
          RD_JALR: begin
            pc_d    = align_pc(jalr_target_e);
            flush_d = 1'b1;
            flush_e = 1'b1;
            taken   = 1'b1;
          end
          RD_BR: begin
            pc_d    = align_pc(br_target_e);
            flush_d = 1'b1;
            flush_e = 1'b1;
            taken   = 1'b1;
          end
          RD_JAL: begin
            pc_d    = align_pc(jal_target_d);
            flush_d = 1'b1;
            taken   = 1'b1;
          end
          default: if (!stall_f) pc_d = pc_q + 32'd4;
        endcase
        // An EX redirect wins; the halt is deferred one cycle.
        if (halt_req || hp_q) begin
          if (ex_redir) begin
            hp_d = 1'b1;
          end else begin
            state_d = ST_HALT;
            pc_d    = pc_q;
            flush_d = 1'b0;
            taken   = 1'b0;
            hp_d    = 1'b0;
          end
        end
      end
      ST_HALT: if (resume) state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
  end

  // First cycle after BOOT/resume and after a redirect is a bubble.
  assign fv_d = (state_q == ST_RUN) && (state_d == ST_RUN) && !taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VECTOR;
      fv_q    <= 1'b0;
      hp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fv_q    <= fv_d;
      hp_q    <= hp_d;
    end
  end

  assign pc_f          = pc_q;
  assign fetch_valid_f = fv_q;
  assign halted        = (state_q == ST_HALT);

`ifdef IF_PERF_EN
  if_perf_counters #(
    .W(PERF_W)
  ) u_perf (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (state_q != ST_HALT),
    .inc_fetch (fv_q),
    .inc_stall ((state_q == ST_RUN) && stall_f && !ex_redir),
    .inc_redir (taken),
    .fetch_cnt (perf_fetch),
    .stall_cnt (perf_stall),
    .redir_cnt (perf_redirect)
  );
`endif

endmodule

// File: tb/tb_if_pc_unit.sv
// Directed self-checking bench for if_pc_unit.
// Counter checks are active when IF_PERF_EN is defined.
module tb_if_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_f, jal_d, br_e, jalr_e;
  logic [31:0] jal_target_d, br_target_e, jalr_target_e;
  logic        halt_req, resume;
  logic [31:0] pc_f;
  logic        fetch_valid_f, flush_d, flush_e, halted;
`ifdef IF_PERF_EN
  logic [31:0] perf_fetch, perf_stall, perf_redirect;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  if_pc_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_f       (stall_f),
    .jal_d         (jal_d),
    .jal_target_d  (jal_target_d),
    .br_e          (br_e),
    .br_target_e   (br_target_e),
    .jalr_e        (jalr_e),
    .jalr_target_e (jalr_target_e),
    .halt_req      (halt_req),
    .resume        (resume),
    .pc_f          (pc_f),
    .fetch_valid_f (fetch_valid_f),
    .flush_d       (flush_d),
    .flush_e       (flush_e),
    .halted        (halted)
`ifdef IF_PERF_EN
    ,
    .perf_fetch    (perf_fetch),
    .perf_stall    (perf_stall),
    .perf_redirect (perf_redirect)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    stall_f  = 0; jal_d = 0; br_e = 0; jalr_e = 0;
    halt_req = 0; resume = 0;
  endtask

  initial begin
    rst_n = 0;
    clr_in();
    jal_target_d = 0; br_target_e = 0; jalr_target_e = 0;
    repeat (2) step();
    check("rst_pc", pc_f, 32'h0);
    check("rst_fv", {31'b0, fetch_valid_f}, 0);
    check("rst_fl", {30'b0, flush_d, flush_e}, 0);
    check("rst_halt", {31'b0, halted}, 0);
`ifdef IF_PERF_EN
    check("rst_pf", perf_fetch, 0);
    check("rst_pr", perf_redirect, 0);
`endif
    rst_n = 1;
    #1;
    check("boot_pc", pc_f, 32'h0);
    check("boot_fv", {31'b0, fetch_valid_f}, 0);
    step();
    check("run0_pc", pc_f, 32'h0);
    check("run0_fv", {31'b0, fetch_valid_f}, 0);
    step();
    check("run1_pc", pc_f, 32'h4);
    check("run1_fv", {31'b0, fetch_valid_f}, 1);
    step();
    check("run2_pc", pc_f, 32'h8);
    step();
    check("run3_pc", pc_f, 32'hC);
    check("run3_fv", {31'b0, fetch_valid_f}, 1);
    repeat (5) step();
    check("seq_pc", pc_f, 32'h20);

    // JAL from ID
    jal_d = 1; jal_target_d = 32'h100; #1;
    check("jal_fd", {31'b0, flush_d}, 1);
    check("jal_fe", {31'b0, flush_e}, 0);
    step(); clr_in(); #1;
    check("jal_pc", pc_f, 32'h100);
    check("jal_fd0", {31'b0, flush_d}, 0);
    check("jal_bub", {31'b0, fetch_valid_f}, 0);
    step();
    check("jal_nx", pc_f, 32'h104);
    check("jal_fv", {31'b0, fetch_valid_f}, 1);

    // Branch overrides stall
    stall_f = 1; br_e = 1; br_target_e = 32'h40; #1;
    check("br_fl", {30'b0, flush_d, flush_e}, 32'h3);
    step(); clr_in(); #1;
    check("br_pc", pc_f, 32'h40);

    // JALR beats branch, low bits masked
    jalr_e = 1; jalr_target_e = 32'h203;
    br_e = 1; br_target_e = 32'h80;
    step(); clr_in(); #1;
    check("jalr_pc", pc_f, 32'h200);
`ifdef IF_PERF_EN
    check("jalr_pr", perf_redirect, 3);
`endif

    // Stalled JAL is deferred
    stall_f = 1; jal_d = 1; jal_target_d = 32'h300; #1;
    check("sj_fd", {31'b0, flush_d}, 0);
    step();
    check("sj_hold", pc_f, 32'h200);
    stall_f = 0; #1;
    check("sj_fd1", {31'b0, flush_d}, 1);
    step(); clr_in(); #1;
    check("sj_pc", pc_f, 32'h300);
`ifdef IF_PERF_EN
    check("sj_ps", perf_stall, 1);
`endif

    // Halt at 0x10
    jalr_e = 1; jalr_target_e = 32'h10;
    step(); clr_in();
    check("h_pre", pc_f, 32'h10);
    halt_req = 1;
    step(); clr_in(); #1;
    check("h_on", {31'b0, halted}, 1);
    check("h_fv", {31'b0, fetch_valid_f}, 0);
    br_e = 1; br_target_e = 32'h999; stall_f = 1; #1;
    check("h_nofl", {30'b0, flush_d, flush_e}, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("h_pc", pc_f, 32'h10);
    end
    clr_in(); resume = 1;
    step(); clr_in(); #1;
    check("res_halt", {31'b0, halted}, 0);
    check("res_pc", pc_f, 32'h10);
    step();
    check("res_nx", pc_f, 32'h14);

    // PC+4 wraps
    jalr_e = 1; jalr_target_e = 32'hFFFF_FFFE;
    step(); clr_in();
    check("wr_pc", pc_f, 32'hFFFF_FFFC);
    step();
    check("wr_0", pc_f, 32'h0);

    // Halt coinciding with redirect
    halt_req = 1; br_e = 1; br_target_e = 32'h50;
    step(); clr_in(); #1;
    check("hc_pc", pc_f, 32'h50);
    check("hc_run", {31'b0, halted}, 0);
    step();
    check("hc_halt", {31'b0, halted}, 1);
    check("hc_hold", pc_f, 32'h50);

    // Async reset mid-HALT
    #2 rst_n = 0; #1;
    check("hr_pc", pc_f, 32'h0);
    check("hr_halt", {31'b0, halted}, 0);
    check("hr_fv", {31'b0, fetch_valid_f}, 0);
    step();
    rst_n = 1;
    step();
    check("hr_boot", pc_f, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
